// File: rtl/line_scan_sequencer_if.sv
// ---------------------------------------------------------------------------
// line_scan_sequencer_if : request/address bundle between scan controller and sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface line_scan_sequencer_if;
  logic       start;
  logic       stop;
  logic       mode;
  logic [4:0] first;
  logic [4:0] last;
  logic [4:0] A;
  logic       en;
  logic       busy;
  logic       done;

  modport master (
    output start, stop, mode, first, last,
    input  A, en, busy, done
  );

  modport slave (
    input  start, stop, mode, first, last,
    output A, en, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/line_scan_sequencer.sv
// ---------------------------------------------------------------------------
// line_scan_sequencer : steps a 5-bit line address over a latched range, DWELL cycles per line
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module line_scan_sequencer #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  line_scan_sequencer_if.slave  bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] C_RELOAD = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

  state_e           state_q;
  logic [4:0]       a_q;
  logic             en_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       first_q;
  logic [4:0]       last_q;
  logic             mode_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= 5'd0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      first_q <= 5'd0;
      last_q  <= 5'd0;
      mode_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.stop) begin
            first_q <= bus.first;
            last_q  <= bus.last;
            mode_q  <= bus.mode;
            a_q     <= bus.first;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= C_RELOAD;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          // Abort leaves A on the line that was being driven.
          if (bus.stop) begin
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - C_ONE;
          end else if (a_q != last_q) begin
            a_q   <= a_q + 5'd1;
            cnt_q <= C_RELOAD;
          end else if (mode_q) begin
            a_q   <= first_q;
            cnt_q <= C_RELOAD;
          end else begin
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          en_q    <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.A    = a_q;
  assign bus.en   = en_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_line_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_line_scan_sequencer : randomized self-checking bench, two DWELL configurations
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_line_scan_sequencer;

  logic clk;
  logic rst;
  logic start, stop, mode;
  logic [4:0] first, last;
  int   sel;
  int   n_tests;
  int   n_fail;
  logic [7:0] obs;

  line_scan_sequencer_if if_d2 ();
  line_scan_sequencer_if if_d1 ();

  assign if_d2.start = start;
  assign if_d2.stop  = stop;
  assign if_d2.mode  = mode;
  assign if_d2.first = first;
  assign if_d2.last  = last;
  assign if_d1.start = start;
  assign if_d1.stop  = stop;
  assign if_d1.mode  = mode;
  assign if_d1.first = first;
  assign if_d1.last  = last;

  line_scan_sequencer #(.DWELL(2), .CNT_W(8)) u_d2 (.clk(clk), .rst(rst), .bus(if_d2));
  line_scan_sequencer #(.DWELL(1), .CNT_W(8)) u_d1 (.clk(clk), .rst(rst), .bus(if_d1));

  // Observation packed as {A, en, busy, done} from the selected instance.
  always_comb begin
    obs = '0;
    if (sel == 1) obs = {if_d1.A, if_d1.en, if_d1.busy, if_d1.done};
    else          obs = {if_d2.A, if_d2.en, if_d2.busy, if_d2.done};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    start = 1'b0; stop = 1'b0; mode = 1'b0; first = 5'd0; last = 5'd0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Reference: line k of a pass is (f + k) mod 32, each shown 'dwell' cycles.
  task automatic run_scan(input int s, input int f, input int l, input int m,
                          input int stop_at, input bit noise, input string name);
    int dwell, len, total, exp_a, last_a;
    logic [7:0] exp;
    sel   = s;
    dwell = (s == 1) ? 1 : 2;
    len   = ((l - f + 32) % 32) + 1;
    total = (stop_at >= 0) ? stop_at : len * dwell;
    apply_reset();
    start = 1'b1; stop = 1'b0; mode = m[0]; first = f[4:0]; last = l[4:0];
    step();
    last_a = 0;
    for (int k = 0; k < total; k++) begin
      if (noise) begin
        start = 1'($urandom % 2);
        mode  = 1'($urandom % 2);
        first = 5'($urandom);
        last  = 5'($urandom);
      end else begin
        start = 1'b0;
      end
      if (k == total - 1) begin
        start = 1'b0;
        stop  = (stop_at >= 0) ? 1'b1 : 1'b0;
      end
      exp_a  = (f + ((k / dwell) % len)) % 32;
      last_a = exp_a;
      exp    = {5'(exp_a), 1'b1, 1'b1, 1'b0};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got A/en/busy/done=%h, expected %h", name, k, obs, exp);
      end
      step();
    end
    stop = 1'b0;
    exp  = (stop_at >= 0) ? {5'(last_a), 3'b000} : {5'(l), 3'b001};
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s end: got A/en/busy/done=%h, expected %h", name, obs, exp);
    end
    step();
    exp[0] = 1'b0;
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s idle-after: got A/en/busy/done=%h, expected %h", name, obs, exp);
    end
  endtask

  task automatic test_reset();
    sel = 0;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      start = 1'($urandom); stop = 1'($urandom); mode = 1'($urandom);
      first = 5'($urandom); last = 5'($urandom);
      step();
      for (int j = 0; j < 2; j++) begin
        sel = j;
        #0;
        n_tests++;
        if (obs !== 8'h00) begin
          n_fail++;
          $display("FAIL reset_hold inst %0d: got %h, expected 00", j, obs);
        end
      end
    end
    rst = 1'b0;
    start = 1'b1; stop = 1'b0; mode = 1'b1; first = 5'd4; last = 5'd9;
    sel = 0;
    step();
    start = 1'b0;
    step(); step(); step();
    n_tests++;
    if (obs[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_async_pre: en got %b, expected 1", obs[2]);
    end
    #3 rst = 1'b1;
    #1;
    n_tests++;
    if (obs !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_async: got %h, expected 00", obs);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_single_pass();
    run_scan(0, 3, 5, 0, -1, 1'b0, "single_pass_d2");
    run_scan(1, 12, 12, 0, -1, 1'b0, "one_line_d1");
  endtask

  task automatic test_wrap();
    run_scan(1, 30, 1, 0, -1, 1'b0, "wrap_d1");
    run_scan(0, 29, 2, 0, -1, 1'b0, "wrap_d2");
  endtask

  task automatic test_continuous();
    run_scan(1, 7, 7, 1, 20, 1'b0, "continuous_d1");
    run_scan(0, 31, 1, 1, 23, 1'b0, "continuous_wrap_d2");
  endtask

  task automatic test_ignored_start();
    run_scan(0, 2, 6, 0, -1, 1'b1, "ignored_start_d2");
    run_scan(1, 20, 25, 1, 30, 1'b1, "ignored_start_cont_d1");
  endtask

  task automatic test_start_stop_idle();
    sel = 1;
    apply_reset();
    start = 1'b1; stop = 1'b1; mode = 1'b0; first = 5'd10; last = 5'd12;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (obs !== 8'h00) begin
        n_fail++;
        $display("FAIL start_stop_idle cycle %0d: got %h, expected 00", i, obs);
      end
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    sel = 1;
    apply_reset();
    start = 1'b1; stop = 1'b0; mode = 1'b0; first = 5'd0; last = 5'd31;
    step();
    for (int k = 0; k < 32; k++) begin
      exp = {5'(k), 3'b110};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL full_range cycle %0d: got %h, expected %h", k, obs, exp);
      end
      step();
    end
    exp = {5'd31, 3'b001};
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL full_range_done: got %h, expected %h", obs, exp);
    end
    step();
    exp = {5'd0, 3'b110};
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL back_to_back_restart: got %h, expected %h", obs, exp);
    end
    start = 1'b0;
    step();
    exp = {5'd1, 3'b110};
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL back_to_back_next: got %h, expected %h", obs, exp);
    end
  endtask

  task automatic test_random();
    int s, f, l, m, len, sa;
    for (int i = 0; i < 30; i++) begin
      s   = int'($urandom % 2);
      f   = int'($urandom % 32);
      l   = int'($urandom % 32);
      m   = int'($urandom % 2);
      len = (((l - f + 32) % 32) + 1) * ((s == 1) ? 1 : 2);
      if (m == 1)                  sa = int'($urandom_range(1, 80));
      else if ($urandom % 3 == 0)  sa = int'($urandom_range(1, len));
      else                         sa = -1;
      run_scan(s, f, l, m, sa, 1'($urandom % 2), "random");
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; sel = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; first = 5'd0; last = 5'd0;
    test_reset();
    test_single_pass();
    test_wrap();
    test_continuous();
    test_ignored_start();
    test_start_stop_idle();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/line_scan_sequencer.md
Name: line_scan_sequencer

Overview:
- Upstream stage of the 5-to-32 line decoder.
- Generates the 5-bit line address A and a decoder enable en that step through a programmed range of lines. Each line is held for a fixed dwell time.
- Supports single-pass and continuous scanning, with wrap-around across line 31 to line 0.
- The decoder's D outputs are gated downstream by en.

Parameters:
- DWELL, 4: number of clock cycles each line is held with en=1. Legal range 1..256.
- CNT_W, 8: width of the dwell counter. Must satisfy 2^CNT_W >= DWELL.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level-sampled request to begin a scan; acted on only in IDLE.
- stop  input  1  abort request; acted on in RUN; dominates start.
- mode  input  1  0 = single pass, 1 = continuous; sampled on accepted start.
- first  input  5  first line of the range; sampled on accepted start.
- last  input  5  last line of the range; sampled on accepted start.
- A  output  5  registered line address to the decoder.
- en  output  1  registered decoder enable; 1 while a line is being driven.
- busy  output  1  1 while in RUN.
- done  output  1  single-cycle pulse marking normal completion of a single pass.

Behaviour:
- Reset, asserted asynchronously at any time: state=IDLE, A=0, en=0, busy=0, done=0, dwell counter=0, latched first/last/mode=0.
- Reset mid-scan: outputs reach reset values immediately, with no done pulse.
- States are IDLE and RUN. All outputs are registered.
- IDLE, start=1 and stop=0 at a rising edge:
  - Latch first, last, mode.
  - Set A=first, en=1, busy=1, counter=DWELL-1.
  - Go to RUN. en/A are valid the cycle after start is sampled (latency 1).
- IDLE, start=1 and stop=1: stay in IDLE; no change.
- RUN, stop=1: at the next edge go to IDLE with en=0, busy=0, done=0. A holds its last value.
- RUN, start=1: ignored. Latched first/last/mode are unaffected by input changes during RUN.
- RUN, counter>0: decrement the counter; A holds.
- RUN, counter==0 and A!=last_latched: A <= A+1 modulo 32 (31 -> 0), counter <= DWELL-1.
- RUN, counter==0 and A==last_latched:
  - mode=1: A <= first_latched, counter <= DWELL-1, stay in RUN. No done pulse.
  - mode=0: go to IDLE with en=0, busy=0, done=1 for exactly one cycle. A holds last.
- Per-line timing: every line is presented with en=1 for exactly DWELL consecutive cycles, with no gap between lines.
- Range length = ((last-first) mod 32)+1 lines, so first>last wraps through 31->0.
- first==last gives a one-line pass.
- The full 32-line range requires last = first-1 mod 32.
- DWELL=1: the counter is always 0, so A advances every cycle.
- done clears on the cycle after it asserts.
- A new start can be accepted in the same cycle that done=1, because the state is then IDLE.

Test Plan:
- Reset:
  - Hold rst=1 with random inputs -> A=0, en=0, busy=0, done=0.
  - Assert rst asynchronously mid-cycle -> outputs clear before the next edge.
- Single pass, DWELL=2, first=3, last=5, mode=0, start for 1 cycle:
  - -> A=3,3,4,4,5,5 with en=1, busy=1 for 6 cycles.
  - -> then en=0, busy=0, done=1 for 1 cycle, A=5.
- Wrap, DWELL=1, first=30, last=1, mode=0:
  - -> A=30,31,0,1 with en=1.
  - -> then done pulse; total 4 enabled cycles.
- Continuous, DWELL=1, first=last=7, mode=1:
  - -> A=7 and en=1 indefinitely, no done.
  - Assert stop -> en=0, busy=0 the next cycle, done stays 0.
- Ignored/dominated requests:
  - start while in RUN with a new first=10 -> scan continues on the originally latched range.
  - start=1 and stop=1 together in IDLE -> remains IDLE, en=0.
- Full range and back-to-back, DWELL=1, first=0, last=31, mode=0:
  - -> 32 cycles A=0..31, then done.
  - start held high through the done cycle -> new scan starts; A=0, en=1 on the next cycle.
